mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter
//   Two-port (instruction / data) round-robin arbiter onto one shared BRAM.
//   Revision: 1.0
// ============================================================================
module mem_arbiter #(
  parameter int addr_width = 32,
  parameter int data_width = 32
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    imem_valid,
  input  logic                    imem_instr,
  input  logic [addr_width-1:0]   imem_addr,
  input  logic [data_width-1:0]   imem_wdata,
  input  logic [data_width/8-1:0] imem_wstrb,
  output logic [data_width-1:0]   imem_rdata,
  output logic                    imem_ready,

  input  logic                    dmem_valid,
  input  logic                    dmem_instr,
  input  logic [addr_width-1:0]   dmem_addr,
  input  logic [data_width-1:0]   dmem_wdata,
  input  logic [data_width/8-1:0] dmem_wstrb,
  output logic [data_width-1:0]   dmem_rdata,
  output logic                    dmem_ready,

  output logic                    bram_valid,
  output logic                    bram_instr,
  output logic [addr_width-1:0]   bram_addr,
  output logic [data_width-1:0]   bram_wdata,
  output logic [data_width/8-1:0] bram_wstrb,
  input  logic [data_width-1:0]   bram_rdata,
  input  logic                    bram_ready
);

  localparam int C_STRB_W = data_width / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_ipend;
  logic                  r_ibuf_instr;
  logic [addr_width-1:0] r_ibuf_addr;
  logic [data_width-1:0] r_ibuf_wdata;
  logic [C_STRB_W-1:0]   r_ibuf_wstrb;

  logic                  r_dpend;
  logic                  r_dbuf_instr;
  logic [addr_width-1:0] r_dbuf_addr;
  logic [data_width-1:0] r_dbuf_wdata;
  logic [C_STRB_W-1:0]   r_dbuf_wstrb;

  // Side encoding for r_last / r_cur / w_gside: 0 = imem, 1 = dmem.
  logic                  r_last;
  logic                  r_cur;

  logic                  w_icand;
  logic                  w_dcand;
  logic                  w_grant;
  logic                  w_gside;
  logic                  w_done;

  logic                  w_sel_instr;
  logic [addr_width-1:0] w_sel_addr;
  logic [data_width-1:0] w_sel_wdata;
  logic [C_STRB_W-1:0]   w_sel_wstrb;

  assign w_icand = r_ipend | imem_valid;
  assign w_dcand = r_dpend | dmem_valid;

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_gside = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_icand || w_dcand) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
          // On a tie the side that did not win last time goes first.
          if (w_icand && w_dcand) w_gside = ~r_last;
          else                    w_gside = w_dcand;
        end
      end
      S_ISSUE: w_next = bram_ready ? S_IDLE : S_WAIT;
      S_WAIT:  if (bram_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A buffered request takes precedence over the live inputs of the same side.
  always_comb begin
    w_sel_instr = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    if (w_gside) begin
      w_sel_instr = r_dpend ? r_dbuf_instr : dmem_instr;
      w_sel_addr  = r_dpend ? r_dbuf_addr  : dmem_addr;
      w_sel_wdata = r_dpend ? r_dbuf_wdata : dmem_wdata;
      w_sel_wstrb = r_dpend ? r_dbuf_wstrb : dmem_wstrb;
    end else begin
      w_sel_instr = r_ipend ? r_ibuf_instr : imem_instr;
      w_sel_addr  = r_ipend ? r_ibuf_addr  : imem_addr;
      w_sel_wdata = r_ipend ? r_ibuf_wdata : imem_wdata;
      w_sel_wstrb = r_ipend ? r_ibuf_wstrb : imem_wstrb;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b0;
      r_cur      <= 1'b0;
      bram_instr <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      bram_wstrb <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_last     <= w_gside;
        r_cur      <= w_gside;
        bram_instr <= w_sel_instr;
        bram_addr  <= w_sel_addr;
        bram_wdata <= w_sel_wdata;
        bram_wstrb <= w_sel_wstrb;
      end
    end
  end

  // Pending flags: a grant of the same side wins over a simultaneous load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ipend      <= 1'b0;
      r_ibuf_instr <= 1'b0;
      r_ibuf_addr  <= '0;
      r_ibuf_wdata <= '0;
      r_ibuf_wstrb <= '0;
      r_dpend      <= 1'b0;
      r_dbuf_instr <= 1'b0;
      r_dbuf_addr  <= '0;
      r_dbuf_wdata <= '0;
      r_dbuf_wstrb <= '0;
    end else begin
      if (imem_valid) begin
        r_ibuf_instr <= imem_instr;
        r_ibuf_addr  <= imem_addr;
        r_ibuf_wdata <= imem_wdata;
        r_ibuf_wstrb <= imem_wstrb;
      end
      if (dmem_valid) begin
        r_dbuf_instr <= dmem_instr;
        r_dbuf_addr  <= dmem_addr;
        r_dbuf_wdata <= dmem_wdata;
        r_dbuf_wstrb <= dmem_wstrb;
      end
      if (w_grant && !w_gside) r_ipend <= 1'b0;
      else if (imem_valid)     r_ipend <= 1'b1;
      if (w_grant && w_gside)  r_dpend <= 1'b0;
      else if (dmem_valid)     r_dpend <= 1'b1;
    end
  end

  assign bram_valid = (r_state == S_ISSUE);
  assign w_done     = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && bram_ready;
  assign imem_ready = w_done && !r_cur;
  assign dmem_ready = w_done && r_cur;
  assign imem_rdata = imem_ready ? bram_rdata : '0;
  assign dmem_rdata = dmem_ready ? bram_rdata : '0;

endmodule
`default_nettype wire
